brent_kung_pipelined_adder: RTL
===============================

Name: brent_kung_pipelined_adder

Overview:
- Parametrised, pipelined successor to the team's fixed 64-bit Brent-Kung adder.
- Width is generic. The Brent-Kung prefix tree is split into a configurable number of register stages.
- Adds an add/subtract mode, signed overflow and zero flags, and a valid/ready stream handshake with backpressure.
- Sits in the datapath between operand-fetch and writeback stages running at the core clock.

Parameters:
- WIDTH, 64: operand width. Must be a power of two, >= 4.
- PIPE, 2: internal pipeline cuts inside the prefix tree, 0..log2(WIDTH). Total latency = PIPE+1 cycles, including the input register.

Ports:
- clk  input  1  core clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  adder can accept a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in (add mode only).
- sub  input  1  0 = A+B+cin; 1 = A-B (A + ~B + 1, cin ignored).
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts result.
- sum  output  WIDTH  result.
- cout  output  1  carry out of bit WIDTH-1 (for sub: 1 means no borrow).
- ovf  output  1  signed overflow.
- zero  output  1  sum == 0.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, sum=0, cout=0, ovf=0, zero=0, all internal valid bits cleared. After reset, in_ready=1.
- Reset mid-operation: all in-flight beats are discarded, none emerges after rst_n releases.
- Stage 0 (input register): captures a, b'=(sub ? ~b : b), c0=(sub ? 1 : cin), and bitwise g=a&b', p=a^b'.
- Prefix tree:
  - Up-sweep: log2(WIDTH) levels, combining span 2^k at bit positions j where (j+1) mod 2^(k+1) == 0.
  - Down-sweep: log2(WIDTH)-1 levels, filling the remaining positions.
  - Carry-in is folded in as generate at position -1, so C[i+1] = Gprefix[i:-1].
  - No ripple chain is permitted.
- Pipeline cuts: the 2*log2(WIDTH)-1 prefix levels are divided into PIPE+1 contiguous groups as evenly as possible, earlier groups taking the extra level. A register sits after every group except the last; the output register follows the last group.
- Sum and flags:
  - sum[i] = p[i] ^ C[i].
  - cout = C[WIDTH].
  - ovf = C[WIDTH] ^ C[WIDTH-1].
  - zero = ~|sum.
  - All outputs are registered.
- Latency: a beat accepted at cycle t appears with out_valid=1 at t+PIPE+1 when there is no stall.
- Throughput: one beat per cycle.
- Handshake:
  - adv = ~out_valid | out_ready.
  - in_ready = adv (combinational).
  - A beat is accepted when in_valid & in_ready.
  - When adv=0, every stage register and valid bit holds.
  - While out_valid=1 and out_ready=0, sum/cout/ovf/zero remain stable.
- Bubbles: no collapsing. A stall freezes the whole pipe, bubbles included. Stage valid bits propagate with their data; registers of invalid beats may update freely but out_valid must be 0 for them.
- Simultaneous accept and output on the same cycle is allowed and gives no throughput loss.
- in_valid with in_ready=0: the beat is not taken. The source must hold it (AXI-style).
- Wrap-around: overflow wraps modulo 2^WIDTH; cout and ovf report it. No saturation.
- PIPE=0: single register after the input register, latency 1.

Test Plan:
- WIDTH=64, PIPE=2: reset, then in_valid=1, a=0xFFFF_FFFF_FFFF_FFFF, b=1, cin=0, sub=0, out_ready=1 -> 3 cycles later out_valid=1, sum=0, cout=1, ovf=0, zero=1.
- Signed overflow: a=0x7FFF_FFFF_FFFF_FFFF, b=1, sub=0 -> sum=0x8000_0000_0000_0000, ovf=1, cout=0. Then sub=1, a=0x8000_0000_0000_0000, b=1 -> sum=0x7FFF_FFFF_FFFF_FFFF, ovf=1, cout=1.
- Back-to-back streaming: 100 random beats, out_ready=1 -> in_ready stays 1, one result per cycle in order, every result matches a reference model including cin in add mode and cin ignored in sub mode.
- Backpressure: stream 5 beats, drop out_ready for 4 cycles once out_valid=1 -> in_ready=0 during the stall, outputs held stable, no beat lost or duplicated, order preserved after out_ready returns.
- Reset mid-flight: accept 2 beats, assert rst_n=0 asynchronously between clock edges -> outputs zero immediately. After release, out_valid stays 0 until a new beat has been accepted and PIPE+1 cycles have elapsed.
- Parameter sweep: WIDTH in {4, 16, 32, 128} × PIPE in {0, 1, log2(WIDTH)} -> exhaustive check for WIDTH=4 (all a, b, cin, sub combinations), random checks for the others. Latency is exactly PIPE+1 in every configuration.

Source files
------------

// File: rtl/brent_kung_pipelined_adder.sv
// Parametrised Brent-Kung adder/subtractor with a configurable number of register
// cuts inside the prefix tree and a valid/ready stream interface.
module brent_kung_pipelined_adder #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned PIPE  = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int unsigned LOGW = $clog2(WIDTH);
    localparam int unsigned NLVL = 2 * LOGW - 1;

    // Levels are split into PIPE+1 contiguous groups, earlier groups taking the remainder.
    function automatic bit cut_after(input int unsigned lv);
        int unsigned acc;
        bit          hit;
        acc = 0;
        hit = 1'b0;
        for (int unsigned q = 0; q < PIPE; q++) begin
            acc += NLVL / (PIPE + 1) + ((q < NLVL % (PIPE + 1)) ? 1 : 0);
            if (lv + 1 == acc) hit = 1'b1;
        end
        return hit;
    endfunction

    logic             w_adv;
    logic [WIDTH-1:0] w_bx;
    logic [WIDTH-1:0] r_g;
    logic [WIDTH-1:0] r_p;
    logic             r_c0;
    logic             r_v;

    assign w_adv    = ~out_valid | out_ready;
    assign in_ready = w_adv;
    assign w_bx     = sub ? ~b : b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_g  <= '0;
            r_p  <= '0;
            r_c0 <= 1'b0;
            r_v  <= 1'b0;
        end else if (w_adv) begin
            r_g  <= a & w_bx;
            r_p  <= a ^ w_bx;
            r_c0 <= sub | cin;
            r_v  <= in_valid;
        end
    end

    // Index k holds the state entering prefix level k; index NLVL is the finished tree.
    logic [NLVL:0][WIDTH-1:0] w_g;
    logic [NLVL:0][WIDTH-1:0] w_p;
    logic [NLVL:0][WIDTH-1:0] w_pb;
    logic [NLVL:0]            w_c0;
    logic [NLVL:0]            w_v;

    // Carry-in enters as the generate of position -1, merged into bit 0.
    assign w_g[0]  = {r_g[WIDTH-1:1], r_g[0] | (r_p[0] & r_c0)};
    assign w_p[0]  = r_p;
    assign w_pb[0] = r_p;
    assign w_c0[0] = r_c0;
    assign w_v[0]  = r_v;

    for (genvar lv = 0; lv < NLVL; lv++) begin : g_lvl
        localparam int unsigned K  = (lv < LOGW) ? lv : 2 * LOGW - 2 - lv;
        localparam int unsigned SP = 1 << K;

        logic [WIDTH-1:0] w_go;
        logic [WIDTH-1:0] w_po;

        for (genvar j = 0; j < WIDTH; j++) begin : g_bit
            localparam bit ACT = (lv < LOGW) ? ((j + 1) % (2 * SP) == 0)
                                             : (((j + 1) % (2 * SP) == SP) && (j + 1 > 2 * SP));
            if (ACT) begin : g_op
                assign w_go[j] = w_g[lv][j] | (w_p[lv][j] & w_g[lv][j-SP]);
                assign w_po[j] = w_p[lv][j] & w_p[lv][j-SP];
            end else begin : g_pass
                assign w_go[j] = w_g[lv][j];
                assign w_po[j] = w_p[lv][j];
            end
        end

        if (cut_after(lv)) begin : g_cut
            logic [WIDTH-1:0] r_gs;
            logic [WIDTH-1:0] r_ps;
            logic [WIDTH-1:0] r_pbs;
            logic             r_c0s;
            logic             r_vs;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_gs  <= '0;
                    r_ps  <= '0;
                    r_pbs <= '0;
                    r_c0s <= 1'b0;
                    r_vs  <= 1'b0;
                end else if (w_adv) begin
                    r_gs  <= w_go;
                    r_ps  <= w_po;
                    r_pbs <= w_pb[lv];
                    r_c0s <= w_c0[lv];
                    r_vs  <= w_v[lv];
                end
            end

            assign w_g[lv+1]  = r_gs;
            assign w_p[lv+1]  = r_ps;
            assign w_pb[lv+1] = r_pbs;
            assign w_c0[lv+1] = r_c0s;
            assign w_v[lv+1]  = r_vs;
        end else begin : g_comb
            assign w_g[lv+1]  = w_go;
            assign w_p[lv+1]  = w_po;
            assign w_pb[lv+1] = w_pb[lv];
            assign w_c0[lv+1] = w_c0[lv];
            assign w_v[lv+1]  = w_v[lv];
        end
    end

    logic [WIDTH:0]   w_c;
    logic [WIDTH-1:0] w_sum;

    assign w_c   = {w_g[NLVL], w_c0[NLVL]};
    assign w_sum = w_pb[NLVL] ^ w_c[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
        end else if (w_adv) begin
            out_valid <= w_v[NLVL];
            sum       <= w_sum;
            cout      <= w_c[WIDTH];
            ovf       <= w_c[WIDTH] ^ w_c[WIDTH-1];
            zero      <= ~|w_sum;
        end
    end
endmodule
